fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  IF pipe stage: owns the PC, fetches words over a req/ack handshake to instruction memory,
//  buffers them in a small FIFO and loads the IF/ID register consumed by ID-stage decode,
//  main control and stall detection. Honours PC_write/IFID_write stalls and branch redirects.
// PARAMETERS
//  PC_RESET   32'h0000_0000  fetch address after reset (bits [1:0] must be 0)
//  BUF_DEPTH  2              fetch FIFO entries; power of two, >=2
// PORTS
//  clock          in   1   single clock; all state updates on rising edge
//  reset          in   1   synchronous, active-high
//  PC_write       in   1   1 = new fetch requests may be issued; 0 = freeze fetch pointer
//  IFID_write     in   1   1 = IF/ID may update; 0 = hold IF/ID (load-use stall)
//  branch_taken   in   1   redirect + flush, from branch resolution
//  branch_target  in   32  redirect address; bits [1:0] ignored (forced 00)
//  imem_req       out  1   fetch request
//  imem_addr      out  32  fetch address, stable while imem_req=1
//  imem_ack       in   1   transfer completes in any cycle with imem_req&&imem_ack
//  imem_rdata     in   32  instruction word, valid in the ack cycle
//  PC             out  32  current fetch pointer
//  IFID_instr     out  32  instruction to ID
//  IFID_PCplus4   out  32  address of IFID_instr + 4
//  IFID_valid     out  1   0 = bubble (IFID_instr=0, sll nop)
// BEHAVIOUR
//  Reset: PC=PC_RESET, FIFO count=0, state IDLE, IFID_instr=0, IFID_PCplus4=0, IFID_valid=0;
//   imem_req=0 in the reset cycle. Reset mid-request drops it; imem shares the reset.
//  FSM (one outstanding request max; imem_req combinational from state):
//   IDLE:    imem_req = PC_write && count<BUF_DEPTH && !branch_taken; imem_addr=PC.
//            req&&ack -> push {rdata,PC+4}, PC+=4, stay IDLE. req&&!ack -> WAIT.
//   WAIT:    imem_req=1, imem_addr held. ack -> push, PC+=4, IDLE. Request never withdrawn.
//   DISCARD: imem_req=1, old addr held; ack -> data dropped, IDLE.
//  Flush (branch_taken=1, priority over every stall): FIFO cleared, IF/ID <= {0,0,valid=0}
//   regardless of IFID_write, PC<=target. WAIT without ack -> DISCARD; ack same cycle ->
//   data dropped, IDLE. Flush while in DISCARD stays DISCARD with new PC.
//  IF/ID load (no flush): IFID_write=1 & count>0 -> pop head into IF/ID, valid=1;
//   IFID_write=1 & count=0 -> bubble; IFID_write=0 -> hold all three outputs.
//  FIFO: push+pop same cycle keeps count; issue gating guarantees no push when full,
//   no overflow/underflow possible. Pointers wrap modulo BUF_DEPTH.
//  Arithmetic: 32-bit unsigned, PC+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000.
//  Latency (zero-wait imem, no stalls): reset released cycle 0 -> req+ack cycle 0,
//   IFID_valid=1 in cycle 2; thereafter one instruction per cycle.
// CONFIGURATION
//  FETCH_BYPASS_EN defined: in an ack cycle with FIFO empty, IFID_write=1, no flush, not
//   DISCARD, data goes straight into IF/ID (no push); first IFID_valid in cycle 1.
//  Not defined: every word passes through the FIFO; first IFID_valid in cycle 2.
//  Order, stall and flush semantics identical in both builds.
// TESTING
//  1 Reset release, zero-wait imem, mem[0]=A,mem[4]=B -> cycle2 (cycle1 w/ bypass): IFID_instr=A,
//    PCplus4=4, valid=1; next cycle B, PCplus4=8.
//  2 IFID_write=PC_write=0 for 3 cycles mid-stream -> IF/ID held, no new req; resume with
//    next sequential word, none lost or duplicated.
//  3 ack delayed 3 cycles; branch_taken, target 0x43 in wait cycle 1 -> imem_addr held until
//    ack, data dropped, next req addr 0x40, IFID_valid=0 the cycle after flush.
//  4 IFID_write=0, PC_write=1 -> count reaches BUF_DEPTH, imem_req stays 0; IFID_write=1 ->
//    req resumes next cycle, words delivered in order.
//  5 PC_RESET=32'hFFFF_FFF8 -> addrs FFF8,FFFC,0000; IFID_PCplus4 FFFC,0000,0004.
//  6 reset asserted during WAIT -> imem_req=0 in that cycle, all outputs at reset values.

Source files
------------

// File: rtl/fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fetch_stage                                                |
// | Description : IF pipe stage. Owns the PC, fetches instruction words over |
// |               a req/ack handshake (one outstanding request), buffers     |
// |               them in a small FIFO and loads the IF/ID register.         |
// |               Honours PC_write / IFID_write stalls and branch redirects. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Parameters  : PC_RESET  - fetch address after reset (bits [1:0] = 0)     |
// |               BUF_DEPTH - fetch FIFO entries, power of two, >= 2         |
// | Ports       : clock, reset (sync, active-high)                           |
// |               PC_write, IFID_write            - stall controls           |
// |               branch_taken, branch_target     - redirect + flush         |
// |               imem_req/imem_addr/imem_ack/imem_rdata - imem handshake    |
// |               PC                              - current fetch pointer    |
// |               IFID_instr/IFID_PCplus4/IFID_valid - IF/ID register        |
// | Build macro : FETCH_BYPASS_EN - when defined, an acked word goes         |
// |               straight into IF/ID if the FIFO is empty and IF/ID is      |
// |               being written (saves one cycle of fetch latency).          |
// +--------------------------------------------------------------------------+
module fetch_stage #(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        PC_write,
    input  logic        IFID_write,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic [31:0] IFID_instr,
    output logic [31:0] IFID_PCplus4,
    output logic        IFID_valid
);

    localparam int c_PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(BUF_DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    // WAIT: request outstanding, data wanted.
    // DISCARD: request outstanding, but a flush made its data stale.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_pc;
    logic [31:0]        r_req_addr;
    logic [31:0]        r_ifid_instr;
    logic [31:0]        r_ifid_pc4;
    logic               r_ifid_valid;
    logic [31:0]        r_fifo_instr [BUF_DEPTH];
    logic [31:0]        r_fifo_pc4   [BUF_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic               w_req;
    logic [31:0]        w_addr;
    logic               w_accept;
    logic               w_bypass;
    logic               w_push;
    logic               w_pop;
    logic               w_fifo_empty;
    logic [31:0]        w_fetch_pc4;
    logic [31:0]        w_target;

    // ---------------- FSM: next state and handshake outputs ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_addr      = r_pc;
        case (r_state)
            ST_IDLE: begin
                // Issue gating on count guarantees a free slot for the reply.
                w_req  = PC_write && (r_count < c_FULL) && !branch_taken;
                w_addr = r_pc;
                if (w_req && !imem_ack) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A request is never withdrawn once issued.
                w_req  = 1'b1;
                w_addr = r_req_addr;
                if (imem_ack) begin
                    w_state_nxt = ST_IDLE;
                end else if (branch_taken) begin
                    w_state_nxt = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                w_req  = 1'b1;
                w_addr = r_req_addr;
                if (imem_ack) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // imem shares the reset, so a pending request simply vanishes.
        if (reset) begin
            w_req = 1'b0;
        end
    end

    // ---------------- datapath control ----------------
    always_comb begin
        w_accept     = w_req && imem_ack && (r_state != ST_DISCARD) && !branch_taken;
        w_fifo_empty = (r_count == '0);
`ifdef FETCH_BYPASS_EN
        w_bypass     = w_accept && w_fifo_empty && IFID_write;
`else
        w_bypass     = 1'b0;
`endif
        w_push       = w_accept && !w_bypass;
        w_pop        = !branch_taken && IFID_write && !w_fifo_empty;
        w_fetch_pc4  = w_addr + 32'd4;
        w_target     = branch_target & 32'hFFFF_FFFC;
    end

    // ---------------- state, PC, FIFO pointers, IF/ID ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_pc         <= PC_RESET;
            r_req_addr   <= PC_RESET;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_ifid_instr <= 32'd0;
            r_ifid_pc4   <= 32'd0;
            r_ifid_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (r_state == ST_IDLE && w_req && !imem_ack) begin
                r_req_addr <= r_pc;
            end

            if (branch_taken) begin
                r_pc <= w_target;
            end else if (w_accept) begin
                r_pc <= r_pc + 32'd4;
            end

            if (branch_taken) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + c_CNT_ONE;
                    2'b01:   r_count <= r_count - c_CNT_ONE;
                    default: r_count <= r_count;
                endcase
            end

            // Flush wins over the load-use stall; a bubble is an sll nop (0).
            if (branch_taken) begin
                r_ifid_instr <= 32'd0;
                r_ifid_pc4   <= 32'd0;
                r_ifid_valid <= 1'b0;
            end else if (w_bypass) begin
                r_ifid_instr <= imem_rdata;
                r_ifid_pc4   <= w_fetch_pc4;
                r_ifid_valid <= 1'b1;
            end else if (IFID_write) begin
                if (w_pop) begin
                    r_ifid_instr <= r_fifo_instr[r_rd_ptr];
                    r_ifid_pc4   <= r_fifo_pc4[r_rd_ptr];
                    r_ifid_valid <= 1'b1;
                end else begin
                    r_ifid_instr <= 32'd0;
                    r_ifid_pc4   <= 32'd0;
                    r_ifid_valid <= 1'b0;
                end
            end
        end
    end

    // FIFO storage carries no reset; the count alone says what is valid.
    always_ff @(posedge clock) begin
        if (w_push && !reset) begin
            r_fifo_instr[r_wr_ptr] <= imem_rdata;
            r_fifo_pc4[r_wr_ptr]   <= w_fetch_pc4;
        end
    end

    assign imem_req     = w_req;
    assign imem_addr    = w_addr;
    assign PC           = r_pc;
    assign IFID_instr   = r_ifid_instr;
    assign IFID_PCplus4 = r_ifid_pc4;
    assign IFID_valid   = r_ifid_valid;

endmodule
`default_nettype wire
